jt51_exp_pipe: RTL and testbench

- Parametrised, pipelined log-to-linear converter for the operator output path.
- Takes a total attenuation word (integer shift part plus fractional part) and a sign, and returns a signed linear sample.
- Synchronous registered ROM, so it maps to block RAM; clock-enable gated; valid and channel-tag handshake for time-multiplexed operator slots.
- Sits between the phase/log-sine stage and the accumulator.

---
 rtl/jt51_exp_pipe.sv | 100 ++++++++++
 tb/tb_jt51_exp_pipe.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/jt51_exp_pipe.sv
// Pipelined log-to-linear converter: registered exp ROM lookup, then shift by
// the integer attenuation, then sign application.
module jt51_exp_pipe #(
  parameter int FRAC_W = 8,
  parameter int INT_W  = 5,
  parameter int MANT_W = 11,
  parameter int CH_W   = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cen,
  input  logic                      in_valid,
  input  logic [CH_W-1:0]           in_ch,
  input  logic [INT_W+FRAC_W-1:0]   atten,
  input  logic                      sign,
  output logic                      out_valid,
  output logic [CH_W-1:0]           out_ch,
  output logic signed [MANT_W+1:0]  lin
);

  localparam int DEPTH = 2 ** FRAC_W;

  // round(2^MANT_W * 2^(-i/DEPTH)), half rounded up; evaluated at elaboration
  function automatic logic [MANT_W:0] rom_entry(input int i);
    real x;
    x = (2.0 ** MANT_W) * (2.0 ** (-real'(i) / real'(DEPTH)));
    return (MANT_W+1)'($rtoi(x + 0.5));
  endfunction

  // Largest magnitude is 2^MANT_W, so one extra bit always holds the negation
  function automatic logic signed [MANT_W+1:0] apply_sign(input logic [MANT_W:0] m,
                                                          input logic s);
    logic signed [MANT_W+1:0] mag;
    mag = signed'({1'b0, m});
    return s ? -mag : mag;
  endfunction

  function automatic logic [MANT_W:0] shift_mag(input logic [MANT_W:0] t,
                                                input logic [INT_W-1:0] sh);
    if (int'(sh) >= MANT_W + 1) return '0;
    return t >> sh;
  endfunction

  logic [MANT_W:0] rom [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_rom
    localparam logic [MANT_W:0] ENTRY = rom_entry(g);
    assign rom[g] = ENTRY;
  end

  logic [FRAC_W-1:0] frac;
  logic [INT_W-1:0]  ishift;

  assign frac   = atten[FRAC_W-1:0];
  assign ishift = atten[INT_W+FRAC_W-1:FRAC_W];

  logic [MANT_W:0]  t_p1;
  logic [INT_W-1:0] int_p1;
  logic             sign_p1;
  logic             vld_p1;
  logic [CH_W-1:0]  ch_p1;

  logic [MANT_W:0]  m_p2;
  logic             sign_p2;
  logic             vld_p2;
  logic [CH_W-1:0]  ch_p2;

  // Stage 1: ROM read; stage 2: shift; data path carries no reset
  always_ff @(posedge clk) begin
    if (cen) begin
      t_p1    <= rom[frac];
      int_p1  <= ishift;
      sign_p1 <= sign;
      m_p2    <= shift_mag(t_p1, int_p1);
      sign_p2 <= sign_p1;
    end
  end

  // Stage 3: signed output; reset flushes every valid bit and clears the outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      ch_p1     <= '0;
      vld_p2    <= 1'b0;
      ch_p2     <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      lin       <= '0;
    end else if (cen) begin
      vld_p1    <= in_valid;
      ch_p1     <= in_ch;
      vld_p2    <= vld_p1;
      ch_p2     <= ch_p1;
      out_valid <= vld_p2;
      out_ch    <= ch_p2;
      lin       <= vld_p2 ? apply_sign(m_p2, sign_p2) : '0;
    end
  end

endmodule

// File: tb/tb_jt51_exp_pipe.sv
// Scoreboard bench for jt51_exp_pipe: driver pushes expected results,
// monitor pops and compares on every enabled clock edge.
module tb_jt51_exp_pipe;
  localparam int FRAC_W = 8;
  localparam int INT_W  = 5;
  localparam int MANT_W = 11;
  localparam int CH_W   = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     cen;
  logic                     in_valid;
  logic [CH_W-1:0]          in_ch;
  logic [INT_W+FRAC_W-1:0]  atten;
  logic                     sign;
  logic                     out_valid;
  logic [CH_W-1:0]          out_ch;
  logic signed [MANT_W+1:0] lin;

  typedef struct {
    bit              v;
    logic [CH_W-1:0] ch;
    int              lin;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   tbl[2**FRAC_W];

  always #5 clk = ~clk;

  jt51_exp_pipe #(
    .FRAC_W (FRAC_W),
    .INT_W  (INT_W),
    .MANT_W (MANT_W),
    .CH_W   (CH_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .atten     (atten),
    .sign      (sign),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .lin       (lin)
  );

  // Reference: exponential table value scaled down by 2^int, floored
  function automatic int model(input logic [INT_W+FRAC_W-1:0] a, input logic s);
    int sh;
    int mag;
    sh  = int'(a[INT_W+FRAC_W-1:FRAC_W]);
    mag = (sh >= MANT_W + 1) ? 0 : tbl[a[FRAC_W-1:0]] / (1 << sh);
    return s ? -mag : mag;
  endfunction

  task automatic check(input string name, input int act, input int req);
    n_chk++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic step(input bit r, input bit c, input bit v, input logic [CH_W-1:0] ch,
                      input logic [INT_W+FRAC_W-1:0] a, input bit s,
                      input bit use_x = 1'b0, input int x = 0);
    exp_t e;
    rst = r; cen = c; in_valid = v; in_ch = ch; atten = a; sign = s;
    if (r) begin
      // Empty pipeline: the next two enabled edges still present bubbles
      q.delete();
      q.push_back('{1'b0, '0, 0});
      q.push_back('{1'b0, '0, 0});
    end else if (c) begin
      e.v   = v;
      e.ch  = ch;
      e.lin = use_x ? x : model(a, s);
      q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic bubble(input bit c);
    step(1'b0, c, 1'b0, CH_W'($urandom), (INT_W+FRAC_W)'($urandom), 1'($urandom));
  endtask

  // Monitor
  initial begin
    bit              a;
    bit              r;
    exp_t            e;
    int              pv;
    int              pl;
    int              pch;
    pv = 0; pl = 0; pch = 0;
    forever begin
      @(posedge clk);
      a = cen;
      r = rst;
      #1;
      if (r) begin
        check("rst_valid", int'(out_valid), 0);
        check("rst_lin", int'(lin), 0);
        check("rst_ch", int'(out_ch), 0);
      end else if (a) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL sb_underflow: got empty queue, required pending entry");
        end else begin
          e = q.pop_front();
          check("valid", int'(out_valid), int'(e.v));
          if (e.v) begin
            check("lin", int'(lin), e.lin);
            check("ch", int'(out_ch), int'(e.ch));
          end else begin
            check("bubble_lin", int'(lin), 0);
          end
        end
      end else begin
        check("hold_valid", int'(out_valid), pv);
        check("hold_lin", int'(lin), pl);
        check("hold_ch", int'(out_ch), pch);
      end
      pv  = int'(out_valid);
      pl  = int'(lin);
      pch = int'(out_ch);
    end
  end

  // Driver
  initial begin
    bit c;
    for (int i = 0; i < 2**FRAC_W; i++)
      tbl[i] = $rtoi($floor((2.0 ** MANT_W) * (2.0 ** (-real'(i) / real'(2**FRAC_W))) + 0.5));

    step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    step(1'b1, 1'b1, 1'b0, '0, '0, 1'b0);

    step(1'b0, 1'b1, 1'b1, 5'd3, 13'd0, 1'b0, 1'b1, 2048);
    repeat (3) bubble(1'b1);

    step(1'b0, 1'b1, 1'b1, 5'd1, {5'd1, 8'd128}, 1'b1, 1'b1, -724);
    step(1'b0, 1'b1, 1'b1, 5'd2, {5'd2, 8'd64},  1'b0, 1'b1, 430);
    step(1'b0, 1'b1, 1'b1, 5'd4, {5'd0, 8'd255}, 1'b0, 1'b1, 1027);
    step(1'b0, 1'b1, 1'b1, 5'd5, {5'd0, 8'd64},  1'b0, 1'b1, 1722);
    step(1'b0, 1'b1, 1'b1, 5'd6, {5'd11, 8'd0},  1'b0, 1'b1, 1);
    step(1'b0, 1'b1, 1'b1, 5'd7, {5'd12, 8'd0},  1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 5'd8, 13'h1FFF,       1'b1, 1'b1, 0);
    step(1'b0, 1'b1, 1'b1, 5'd9, 13'd0,          1'b1, 1'b1, -2048);
    repeat (3) bubble(1'b1);

    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 1'b1, CH_W'(i + 10), (INT_W+FRAC_W)'($urandom_range(0, 3071)), 1'($urandom));
      bubble(1'b0);
      bubble(1'b0);
    end
    repeat (3) bubble(1'b1);

    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 1'b1, CH_W'(20 + i), (INT_W+FRAC_W)'($urandom_range(0, 2047)), 1'($urandom));
    step(1'b1, 1'b0, 1'b1, 5'd31, 13'd0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 1'b1, CH_W'(24 + i), (INT_W+FRAC_W)'($urandom_range(0, 2047)), 1'($urandom));
    repeat (3) bubble(1'b1);

    for (int s = 0; s < 2; s++) begin
      for (int a = 0; a < 2**(INT_W+FRAC_W); a++) begin
        while ($urandom_range(0, 3) == 0) bubble(1'($urandom));
        do begin
          c = ($urandom_range(0, 3) != 0);
          step(1'b0, c, 1'b1, CH_W'($urandom), (INT_W+FRAC_W)'(a), 1'(s));
        end while (!c);
      end
    end
    repeat (4) bubble(1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
